// File: rtl/m_ext_sequencer_if.sv
// EX-stage <-> RV32M sequencer signal bundle.
// master = EX pipeline side, slave = sequencer.
interface m_ext_sequencer_if;
  logic        start;
  logic        flush;
  logic [2:0]  func3;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [4:0]  rd_in;
  logic        stall;
  logic        busy;
  logic        result_valid;
  logic [31:0] result;
  logic [4:0]  rd_out;

  modport master (
    output start, flush, func3,
    output op_a, op_b, rd_in,
    input  stall, busy, result_valid,
    input  result, rd_out
  );

  modport slave (
    input  start, flush, func3,
    input  op_a, op_b, rd_in,
    output stall, busy, result_valid,
    output result, rd_out
  );
endinterface

// File: rtl/m_ext_sequencer.sv
// RV32M iterative multiply/divide sequencer (IDLE/BUSY/DONE).
// Define M_FAST_MUL_EN for a single-cycle combinational multiply path.
module m_ext_sequencer #(
  parameter int UNROLL = 1
) (
  input  logic clk,
  input  logic rst,
  m_ext_sequencer_if.slave mx
);

  localparam int N = 32 / UNROLL;
  localparam logic [5:0] LAST = 6'(N - 1);

  typedef enum logic [1:0] {
    IDLE, BUSY, DONE
  } state_t;

  state_t      state, state_nx;
  logic [2:0]  f3_q;
  logic        neg_q, byp_q;
  logic [31:0] hi_q, lo_q, m_q;
  logic [31:0] res_q, fin;
  logic [5:0]  cnt_q;
  logic [4:0]  rd_q;

  logic        is_div, a_sgn, b_sgn;
  logic        neg_a, neg_b;
  logic [31:0] mag_a, mag_b;
  logic        b_zero, ovf, corner;
  logic [31:0] corner_val;
  logic        fast, accept;

  always_comb begin
    is_div = mx.func3[2];
    a_sgn  = is_div ? ~mx.func3[0]
                    : ~(mx.func3[1] & mx.func3[0]);
    b_sgn  = is_div ? ~mx.func3[0] : ~mx.func3[1];
    neg_a  = a_sgn & mx.op_a[31];
    neg_b  = b_sgn & mx.op_b[31];
    mag_a  = neg_a ? -mx.op_a : mx.op_a;
    mag_b  = neg_b ? -mx.op_b : mx.op_b;
    b_zero = mx.op_b == 32'h0;
    ovf    = ~mx.func3[0] &
             (mx.op_a == 32'h8000_0000) &
             (mx.op_b == 32'hFFFF_FFFF);
    corner = is_div & (b_zero | ovf);
    if (b_zero)
      corner_val = mx.func3[1] ? mx.op_a
                               : 32'hFFFF_FFFF;
    else
      corner_val = mx.func3[1] ? 32'h0
                               : 32'h8000_0000;
`ifdef M_FAST_MUL_EN
    fast = ~is_div;
`else
    fast = 1'b0;
`endif
    accept = (state == IDLE) & mx.start & ~mx.flush;
  end

  // One radix-2 step per unrolled bit: restoring divide or shift-add multiply.
  function automatic logic [63:0] step(
    input logic        div,
    input logic [31:0] h_in,
    input logic [31:0] l_in,
    input logic [31:0] m
  );
    logic [31:0] h, l;
    logic [32:0] t;
    h = h_in;
    l = l_in;
    for (int k = 0; k < UNROLL; k++) begin
      if (div) begin
        t = {h, l[31]};
        l = {l[30:0], 1'b0};
        if (t >= {1'b0, m}) begin
          t = t - {1'b0, m};
          l[0] = 1'b1;
        end
        h = t[31:0];
      end else begin
        t = {1'b0, h} +
            (l[0] ? {1'b0, m} : 33'd0);
        h = t[32:1];
        l = {t[0], l[31:1]};
      end
    end
    return {h, l};
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:
        if (accept)
          state_nx = (corner | fast) ? DONE : BUSY;
      BUSY:
        if (mx.flush)
          state_nx = IDLE;
        else if (cnt_q == LAST)
          state_nx = DONE;
      DONE:
        state_nx = IDLE;
      default:
        state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      f3_q  <= '0;
      rd_q  <= '0;
      neg_q <= 1'b0;
      byp_q <= 1'b0;
      cnt_q <= '0;
      m_q   <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
      res_q <= '0;
    end else begin
      if (accept) begin
        f3_q  <= mx.func3;
        rd_q  <= mx.rd_in;
        neg_q <= (is_div & mx.func3[1]) ? neg_a
                                        : neg_a ^ neg_b;
        byp_q <= corner;
        cnt_q <= '0;
        m_q   <= is_div ? mag_b : mag_a;
        hi_q  <= '0;
        lo_q  <= corner ? corner_val
               : is_div ? mag_a : mag_b;
`ifdef M_FAST_MUL_EN
        if (fast)
          {hi_q, lo_q} <= 64'(mag_a) * 64'(mag_b);
`endif
      end else if (state == BUSY) begin
        {hi_q, lo_q} <= step(f3_q[2], hi_q,
                             lo_q, m_q);
        cnt_q <= cnt_q + 6'd1;
      end
      if (state == DONE)
        res_q <= fin;
    end
  end

  logic [63:0] prod, prod_c;
  logic [31:0] quo_c, rem_c;

  always_comb begin
    prod   = {hi_q, lo_q};
    prod_c = neg_q ? -prod : prod;
    quo_c  = neg_q ? -lo_q : lo_q;
    rem_c  = neg_q ? -hi_q : hi_q;
    fin    = '0;
    unique case (1'b1)
      byp_q:
        fin = lo_q;
      ~byp_q & ~f3_q[2] & (f3_q[1:0] == 2'b00):
        fin = prod_c[31:0];
      ~byp_q & ~f3_q[2] & (f3_q[1:0] != 2'b00):
        fin = prod_c[63:32];
      ~byp_q & f3_q[2] & ~f3_q[1]:
        fin = quo_c;
      ~byp_q & f3_q[2] & f3_q[1]:
        fin = rem_c;
      default:
        fin = '0;
    endcase
  end

  always_comb begin
    mx.stall        = accept | (state == BUSY);
    mx.busy         = state != IDLE;
    mx.result_valid = state == DONE;
    mx.result       = (state == DONE) ? fin : res_q;
    mx.rd_out       = rd_q;
  end

endmodule

// File: tb/tb_m_ext_sequencer.sv
// Directed self-checking bench for m_ext_sequencer.
// Covers latency, corner cases, flush and async reset.
module tb_m_ext_sequencer;

  localparam int N = 32;
`ifdef M_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = N + 1;
`endif

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;
  logic [31:0] last_exp = '0;

  always #5 clk = ~clk;

  m_ext_sequencer_if mx();

  m_ext_sequencer #(.UNROLL(1)) dut (
    .clk (clk),
    .rst (rst),
    .mx  (mx)
  );

  task automatic chk(string tag,
                     logic [31:0] got,
                     logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h",
               tag, got, exp);
    end
  endtask

  task automatic chk_zero(string tag);
    chk({tag, " stall"}, 32'(mx.stall), 0);
    chk({tag, " busy"}, 32'(mx.busy), 0);
    chk({tag, " valid"}, 32'(mx.result_valid), 0);
    chk({tag, " result"}, mx.result, 0);
    chk({tag, " rd_out"}, 32'(mx.rd_out), 0);
  endtask

  task automatic run_op(string tag,
                        logic [2:0] f3,
                        logic [31:0] a,
                        logic [31:0] b,
                        logic [4:0] rd,
                        logic [31:0] exp,
                        int lat_exp);
    int lat;
    int stl;
    bit seen;
    @(negedge clk);
    mx.start = 1'b1;
    mx.func3 = f3;
    mx.op_a  = a;
    mx.op_b  = b;
    mx.rd_in = rd;
    #1;
    stl  = 32'(mx.stall);
    lat  = 0;
    seen = 1'b0;
    @(posedge clk);
    #1;
    mx.start = 1'b0;
    mx.func3 = ~f3;
    mx.op_a  = ~a;
    mx.op_b  = b ^ 32'h5A5A_5A5A;
    mx.rd_in = ~rd;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      lat++;
      if (mx.result_valid)
        seen = 1'b1;
      else
        stl += 32'(mx.stall);
    end
    chk({tag, " valid"}, 32'(seen), 1);
    chk({tag, " result"}, mx.result, exp);
    chk({tag, " rd_out"}, 32'(mx.rd_out), 32'(rd));
    chk({tag, " latency"}, lat, lat_exp);
    chk({tag, " stall_cycles"}, stl, lat_exp);
    chk({tag, " stall_done"}, 32'(mx.stall), 0);
    @(negedge clk);
    chk({tag, " pulse"}, 32'(mx.result_valid), 0);
    chk({tag, " held"}, mx.result, exp);
    last_exp = exp;
  endtask

  initial begin
    rst      = 1'b1;
    mx.start = 1'b0;
    mx.flush = 1'b0;
    mx.func3 = '0;
    mx.op_a  = '0;
    mx.op_b  = '0;
    mx.rd_in = '0;
    #2;
    chk_zero("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    run_op("div", 3'b100, 32'd100, 32'hFFFF_FFF9,
           5'd1, 32'hFFFF_FFF2, N + 1);
    run_op("rem", 3'b110, 32'd100, 32'hFFFF_FFF9,
           5'd2, 32'h0000_0002, N + 1);
    run_op("divu0", 3'b101, 32'h1234_5678, 32'h0,
           5'd3, 32'hFFFF_FFFF, 1);
    run_op("remu0", 3'b111, 32'h1234_5678, 32'h0,
           5'd4, 32'h1234_5678, 1);
    run_op("divovf", 3'b100, 32'h8000_0000,
           32'hFFFF_FFFF, 5'd5, 32'h8000_0000, 1);
    run_op("removf", 3'b110, 32'h8000_0000,
           32'hFFFF_FFFF, 5'd6, 32'h0, 1);
    run_op("mul", 3'b000, 32'hFFFF_FFFF,
           32'hFFFF_FFFF, 5'd7, 32'h1, MUL_LAT);
    run_op("mulh", 3'b001, 32'hFFFF_FFFF,
           32'hFFFF_FFFF, 5'd8, 32'h0, MUL_LAT);
    run_op("mulhu", 3'b011, 32'hFFFF_FFFF,
           32'hFFFF_FFFF, 5'd9, 32'hFFFF_FFFE, MUL_LAT);
    run_op("mulhsu", 3'b010, 32'hFFFF_FFFF,
           32'hFFFF_FFFF, 5'd10, 32'hFFFF_FFFF, MUL_LAT);
    run_op("divneg", 3'b100, 32'hFFFF_FF9C, 32'd7,
           5'd11, 32'hFFFF_FFF2, N + 1);
    run_op("remneg", 3'b110, 32'hFFFF_FF9C, 32'd7,
           5'd12, 32'hFFFF_FFFE, N + 1);
    run_op("divu", 3'b101, 32'd100, 32'd7,
           5'd13, 32'd14, N + 1);
    run_op("remu", 3'b111, 32'd100, 32'd7,
           5'd14, 32'd2, N + 1);
    run_op("mulneg", 3'b000, 32'd7, 32'hFFFF_FFFD,
           5'd15, 32'hFFFF_FFEB, MUL_LAT);
    run_op("div0", 3'b100, 32'd5, 32'h0,
           5'd16, 32'hFFFF_FFFF, 1);
    run_op("rem0", 3'b110, 32'd5, 32'h0,
           5'd17, 32'd5, 1);

    // flush a DIVU at BUSY cycle 10
    @(negedge clk);
    mx.start = 1'b1;
    mx.func3 = 3'b101;
    mx.op_a  = 32'd1000;
    mx.op_b  = 32'd3;
    mx.rd_in = 5'd20;
    @(posedge clk);
    #1;
    mx.start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    chk("flush pre busy", 32'(mx.busy), 1);
    mx.flush = 1'b1;
    @(posedge clk);
    #1;
    mx.flush = 1'b0;
    chk("flush busy", 32'(mx.busy), 0);
    chk("flush stall", 32'(mx.stall), 0);
    chk("flush valid", 32'(mx.result_valid), 0);
    chk("flush result", mx.result, last_exp);
    run_op("postflush", 3'b101, 32'd1000, 32'd3,
           5'd21, 32'd333, N + 1);

    // async reset at BUSY cycle 5
    @(negedge clk);
    mx.start = 1'b1;
    mx.func3 = 3'b101;
    mx.op_a  = 32'd77;
    mx.op_b  = 32'd5;
    mx.rd_in = 5'd22;
    @(posedge clk);
    #1;
    mx.start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    chk("prerst busy", 32'(mx.busy), 1);
    chk("prerst rd_out", 32'(mx.rd_out), 22);
    rst = 1'b1;
    #1;
    chk_zero("midrst");
    @(negedge clk);
    rst = 1'b0;
    run_op("postrst", 3'b000, 32'd7, 32'hFFFF_FFFD,
           5'd23, 32'hFFFF_FFEB, MUL_LAT);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
